// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
// grant is one-hot-or-zero and feeds the downstream unique-case enable mux.
interface rr_onehot_arbiter_if #(
  parameter int N = 3
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             timeout;

  modport master (
    output req, done,
    input  grant, grant_valid, grant_idx, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_valid, grant_idx, timeout
  );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with bounded hold and a one-cycle break-before-make gap.
// Handshake: a grant is held while req[grant_idx] stays high and done is low,
// for at most MAX_HOLD cycles; any release is followed by one idle cycle.
module rr_onehot_arbiter #(
  parameter int N        = 3,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst,
  rr_onehot_arbiter_if.slave  bus,
  output logic                state_dbg
);
  localparam int IDX_W = $clog2(N);
  localparam int HC_W  = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [HC_W-1:0]  hold_cnt, hold_nxt;
  logic [N-1:0]     grant_r, grant_nxt;
  logic [IDX_W-1:0] idx_r, idx_nxt;
  logic             valid_r, valid_nxt;
  logic             timeout_r, timeout_nxt;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             release_c;
  logic             limit_hit;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      grant_r   <= '0;
      idx_r     <= '0;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      grant_r   <= grant_nxt;
      idx_r     <= idx_nxt;
      valid_r   <= valid_nxt;
      timeout_r <= timeout_nxt;
    end
  end

  // Rotating priority scan starting at ptr, wrapping past N-1 to 0.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!sel_found && bus.req[(int'(ptr) + k) % N]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'((int'(ptr) + k) % N);
      end
    end
  end

  assign limit_hit = (hold_cnt == HOLD_MAX);
  assign release_c = bus.done || !bus.req[idx_r] || limit_hit;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = GRANT;
      GRANT:   if (release_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered output / datapath next values
  always_comb begin
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    grant_nxt   = grant_r;
    idx_nxt     = idx_r;
    valid_nxt   = valid_r;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        idx_nxt   = '0;
        valid_nxt = 1'b0;
        hold_nxt  = '0;
        if (sel_found) begin
          grant_nxt[sel_idx] = 1'b1;
          idx_nxt   = sel_idx;
          valid_nxt = 1'b1;
          hold_nxt  = HC_W'(1);
        end
      end
      GRANT: begin
        if (release_c) begin
          grant_nxt   = '0;
          idx_nxt     = '0;
          valid_nxt   = 1'b0;
          hold_nxt    = '0;
          ptr_nxt     = (idx_r == LAST_IDX) ? '0 : idx_r + 1'b1;
          // done takes precedence over the hold limit
          timeout_nxt = limit_hit && !bus.done && bus.req[idx_r];
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        grant_nxt = '0;
        idx_nxt   = '0;
        valid_nxt = 1'b0;
        hold_nxt  = '0;
      end
    endcase
  end

  assign bus.grant       = grant_r;
  assign bus.grant_valid = valid_r;
  assign bus.grant_idx   = idx_r;
  assign bus.timeout     = timeout_r;
  assign state_dbg       = state;
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter (N=3, MAX_HOLD=4) with a scoreboard
// of expected {timeout, grant} per cycle plus per-cycle invariant checks.
module tb_rr_onehot_arbiter;
  localparam int N        = 3;
  localparam int MAX_HOLD = 4;
  localparam int IDX_W    = $clog2(N);

  logic clk;
  logic rst;
  logic state_dbg;
  int   total;
  int   bad;
  logic [N:0] exp_q[$];

  rr_onehot_arbiter_if #(.N(N)) bus ();

  rr_onehot_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IDX_W-1:0] idx_of(input logic [N-1:0] g);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (g[i]) r = IDX_W'(i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Driver: apply inputs, queue the outputs expected after the next edge, then score them.
  task automatic step(input logic [N-1:0] r, input logic d,
                      input logic [N-1:0] eg, input logic et);
    logic [N:0] e;
    bus.req  = r;
    bus.done = d;
    exp_q.push_back({et, eg});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("grant",       8'(bus.grant),       8'(e[N-1:0]));
    check("grant_valid", 8'(bus.grant_valid), 8'(|e[N-1:0]));
    check("grant_idx",   8'(bus.grant_idx),   8'(idx_of(e[N-1:0])));
    check("timeout",     8'(bus.timeout),     8'(e[N]));
  endtask

  // Invariants sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_onehot0", 8'($onehot0(bus.grant)), 8'(1));
      check("inv_valid",   8'(bus.grant_valid),     8'(|bus.grant));
      if (bus.grant_valid)
        check("inv_idx", 8'(bus.grant), 8'(1 << bus.grant_idx));
      if (bus.timeout)
        check("inv_timeout_gap", 8'(bus.grant), 8'(0));
    end
  end

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;
    #1;
    check("reset_grant",   8'(bus.grant),       8'(0));
    check("reset_valid",   8'(bus.grant_valid), 8'(0));
    check("reset_idx",     8'(bus.grant_idx),   8'(0));
    check("reset_timeout", 8'(bus.timeout),     8'(0));
    check("reset_state",   8'(state_dbg),       8'(0));
    @(negedge clk);
    #2 rst = 1'b0;
    step(3'b000, 1'b0, 3'b000, 1'b0);

    // 1: all requesting, done on the 2nd grant cycle of each owner
    step(3'b111, 1'b0, 3'b001, 1'b0);
    step(3'b111, 1'b0, 3'b001, 1'b0);
    step(3'b111, 1'b1, 3'b000, 1'b0);
    step(3'b111, 1'b0, 3'b010, 1'b0);
    step(3'b111, 1'b0, 3'b010, 1'b0);
    step(3'b111, 1'b1, 3'b000, 1'b0);
    step(3'b111, 1'b0, 3'b100, 1'b0);
    step(3'b111, 1'b0, 3'b100, 1'b0);
    step(3'b111, 1'b1, 3'b000, 1'b0);
    step(3'b111, 1'b0, 3'b001, 1'b0);
    step(3'b111, 1'b1, 3'b000, 1'b0);

    // 2: wraparound scan from ptr=1 to requester 0
    step(3'b001, 1'b0, 3'b001, 1'b0);
    step(3'b001, 1'b1, 3'b000, 1'b0);

    // 3: hold timeout, two full periods
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < MAX_HOLD; c++) step(3'b010, 1'b0, 3'b010, 1'b0);
      step(3'b010, 1'b0, 3'b000, 1'b1);
    end

    // 4: done coincides with the hold limit
    for (int c = 0; c < MAX_HOLD; c++) step(3'b100, 1'b0, 3'b100, 1'b0);
    step(3'b100, 1'b1, 3'b000, 1'b0);
    step(3'b000, 1'b0, 3'b000, 1'b0);

    // 5: request drop mid-grant
    step(3'b011, 1'b0, 3'b001, 1'b0);
    step(3'b011, 1'b1, 3'b000, 1'b0);
    step(3'b011, 1'b0, 3'b010, 1'b0);
    step(3'b001, 1'b0, 3'b000, 1'b0);
    step(3'b011, 1'b0, 3'b001, 1'b0);
    step(3'b000, 1'b0, 3'b000, 1'b0);

    // 6: asynchronous reset while grant=100, hold_cnt=2
    step(3'b100, 1'b0, 3'b100, 1'b0);
    step(3'b100, 1'b0, 3'b100, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_grant",   8'(bus.grant),       8'(0));
    check("async_valid",   8'(bus.grant_valid), 8'(0));
    check("async_idx",     8'(bus.grant_idx),   8'(0));
    check("async_timeout", 8'(bus.timeout),     8'(0));
    bus.req = 3'b110;
    @(negedge clk);
    #2 rst = 1'b0;
    step(3'b110, 1'b0, 3'b010, 1'b0);
    step(3'b110, 1'b1, 3'b000, 1'b0);
    step(3'b110, 1'b0, 3'b100, 1'b0);

    // Random traffic, covered by the invariant checks
    for (int i = 0; i < 200; i++) begin
      bus.req  = N'($urandom_range(0, (1 << N) - 1));
      bus.done = ($urandom_range(0, 5) == 0);
      @(posedge clk);
      #1;
    end

    check("scoreboard_empty", 8'(exp_q.size()), 8'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
Round-robin arbiter that generates the one-hot enable vector consumed by the downstream unique-case select mux (en_a/en_b/en_c style). It guarantees at most one enable is active at any time, so the downstream unique case never raises a multiple-match warning. It holds each grant until release or timeout, then rotates priority. It also supplies a binary index for muxes decoded by a case on the index.

Parameters:
N, 3, number of requesters/enables (N >= 2)
MAX_HOLD, 8, maximum consecutive cycles one grant may be held (>= 1)
(derived localparam IDX_W = $clog2(N); not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req  input  N  request vector; bit i = requester i
done  input  1  current owner finished; sampled only while a grant is active
grant  output  N  registered one-hot-or-zero enable vector to the downstream mux
grant_valid  output  1  registered; equals |grant
grant_idx  output  IDX_W  registered binary index of the granted bit; 0 when grant == 0
timeout  output  1  registered one-cycle pulse; previous grant was force-released at MAX_HOLD

Behaviour:
- Reset is asynchronous, active-high, and acts immediately without a clock edge. While rst is high: grant = 0, grant_valid = 0, grant_idx = 0, timeout = 0, state = IDLE, ptr = 0, hold_cnt = 0.
- Internal state:
  - ptr (IDX_W bits): index with highest priority.
  - hold_cnt: counts 1..MAX_HOLD.
  - FSM: IDLE or GRANT.
- IDLE:
  - done is ignored.
  - If req != 0 at a clock edge, select the first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Next cycle: grant = one-hot of the selected index, grant_idx = that index, grant_valid = 1, hold_cnt = 1, state = GRANT.
  - Latency from a req rising in IDLE to grant is 1 cycle.
  - If req == 0, stay in IDLE; all outputs remain 0, except timeout, which follows the rules below.
- GRANT:
  - grant and grant_idx are held stable.
  - At each clock edge, evaluate the release condition R = done OR !req[grant_idx] OR (hold_cnt == MAX_HOLD).
  - If R is false: hold_cnt increments.
  - If R is true:
    - Next cycle grant = 0, grant_valid = 0, grant_idx = 0, state = IDLE, hold_cnt = 0.
    - ptr = (grant_idx + 1) mod N, wrapping from N-1 to 0.
  - Result: a grant is visible for at most MAX_HOLD cycles.
- timeout:
  - Set to 1 for exactly the first IDLE cycle after a release caused only by hold_cnt == MAX_HOLD (done = 0 and req[grant_idx] = 1 at that edge).
  - Otherwise 0.
  - If done and the hold limit coincide, done wins and timeout stays 0.
- Gap: every release is followed by exactly one cycle with grant = 0, even if requests are pending. This is the break-before-make gap; the downstream mux sees no overlap.
- Re-arbitration after release uses the updated ptr, so the previous owner has lowest priority. A sole requester is re-granted after the 1-cycle gap.
- req changes on bits other than grant_idx during GRANT have no effect until the next IDLE.
- Invariants, checked every cycle by the bench:
  - $onehot0(grant).
  - grant_valid == |grant.
  - When grant_valid = 1, grant == (1 << grant_idx).
  - timeout implies grant == 0.

Test Plan:
1. N=3, MAX_HOLD=4. Release rst, hold req=3'b111, pulse done for 1 cycle on the 2nd grant cycle of each owner -> grant sequence 001, 000, 010, 000, 100, 000, 001; grant_idx 0, 1, 2, 0; timeout never 1.
2. Wraparound: after test 1 leaves ptr=1, drive req=3'b001 only -> grant=001 one cycle later (scan 1 -> 2 -> 0 wraps). Release with done -> ptr=1.
3. Hold timeout: req=3'b010, done=0 constant -> grant=010 for exactly 4 cycles, then grant=000 with timeout=1 for 1 cycle, then grant=010 again; pattern repeats every 5 cycles.
4. Coincident done and limit: req=3'b100, assert done on the 4th grant cycle (hold_cnt=4) -> grant clears next cycle, timeout stays 0.
5. Request drop: granted bit 1 (grant=010), drop req[1] mid-grant with done=0 -> grant=000 next cycle, timeout=0, ptr=2; with req=3'b011 still pending, next grant is 001.
6. Async reset mid-grant: while grant=100 and hold_cnt=2, assert rst between clock edges -> grant, grant_valid, grant_idx, timeout go to 0 immediately. After deassertion with req=3'b110, first grant is 010 (ptr reset to 0).
